// File: rtl/vga_mem_arb_if.sv
// Memory command / read-return port between the VGA arbiter (master) and
// the frame-buffer memory (slave).
interface vga_mem_arb_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_cmd_valid, mem_we, mem_addr, mem_wdata,
        input  mem_cmd_ready, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_cmd_valid, mem_we, mem_addr, mem_wdata,
        output mem_cmd_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/vga_mem_arb.sv
// Frame-buffer arbiter: display line-fetch bursts vs single host writes.
// Define VGA_ARB_FAIR_EN to serve one pending host write after every display burst.
module vga_mem_arb #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblank_i,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    input  logic [LEN_W-1:0]  disp_len_i,
    output logic              disp_gnt_o,
    output logic              disp_rvalid_o,
    output logic [DATA_W-1:0] disp_rdata_o,
    output logic              disp_done_o,
    input  logic              host_req_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,
    vga_mem_arb_if.master     mem
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] DISP_ISSUE = 2'd1;
    localparam logic [1:0] DISP_DRAIN = 2'd2;
    localparam logic [1:0] HOST_WR    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W:0]    outs_q, outs_d;
    logic              gnt_q, gnt_d;
    logic              done_q, done_d;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_acc, rd_ret, host_first;
`ifdef VGA_ARB_FAIR_EN
    logic              host_turn_q, host_turn_d;
`endif

    // Arbitration is identical inside and outside blanking.
    logic unused_vblank;
    assign unused_vblank = vblank_i;

    assign rd_acc = (state_q == DISP_ISSUE) && mem.mem_cmd_ready;
    // Returns with nothing outstanding are strays (e.g. after a reset) and are dropped.
    assign rd_ret = mem.mem_rvalid && (outs_q != '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        gnt_d   = 1'b0;
        done_d  = 1'b0;
        outs_d  = outs_q + {{LEN_W{1'b0}}, rd_acc} - {{LEN_W{1'b0}}, rd_ret};
`ifdef VGA_ARB_FAIR_EN
        host_turn_d = host_turn_q;
        host_first  = host_turn_q && host_req_i;
`else
        host_first  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (disp_req_i && !host_first) begin
                    addr_d  = disp_addr_i;
                    rem_d   = disp_len_i;
                    gnt_d   = 1'b1;
                    state_d = (disp_len_i == '0) ? DISP_DRAIN : DISP_ISSUE;
                end else if (host_req_i) begin
                    state_d = HOST_WR;
                end
`ifdef VGA_ARB_FAIR_EN
                if (disp_req_i || host_req_i) host_turn_d = 1'b0;
`endif
            end
            DISP_ISSUE: begin
                if (mem.mem_cmd_ready) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) state_d = DISP_DRAIN;
                end
            end
            DISP_DRAIN: begin
                // done lines up with the registered copy of the final return
                if ((outs_q == '0) || (outs_q == (LEN_W+1)'(1) && mem.mem_rvalid)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef VGA_ARB_FAIR_EN
                    host_turn_d = 1'b1;
`endif
                end
            end
            HOST_WR: begin
                if (mem.mem_cmd_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            outs_q   <= '0;
            gnt_q    <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
`ifdef VGA_ARB_FAIR_EN
            host_turn_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            outs_q   <= outs_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rvalid_q <= rd_ret;
            if (rd_ret) rdata_q <= mem.mem_rdata;
`ifdef VGA_ARB_FAIR_EN
            host_turn_q <= host_turn_d;
`endif
        end
    end

    assign mem.mem_cmd_valid = (state_q == DISP_ISSUE) || (state_q == HOST_WR);
    assign mem.mem_we        = (state_q == HOST_WR);
    assign mem.mem_addr      = (state_q == HOST_WR)    ? host_addr_i :
                               (state_q == DISP_ISSUE) ? addr_q      : '0;
    assign mem.mem_wdata     = (state_q == HOST_WR) ? host_wdata_i : '0;

    assign host_gnt_o    = (state_q == HOST_WR) && mem.mem_cmd_ready;
    assign disp_gnt_o    = gnt_q;
    assign disp_done_o   = done_q;
    assign disp_rvalid_o = rvalid_q;
    assign disp_rdata_o  = rdata_q;
endmodule
